decoder3to8_pipe: RTL and testbench
===================================

Name: decoder3to8_pipe

Overview:
Registered 3-to-8 one-hot decoder with valid/ready handshakes on both sides. It is the receive-side counterpart of the 8-to-3 encoder and turns a binary code back into a one-hot select. A 2-entry output buffer absorbs downstream back-pressure without dropping codes. A transaction counter supports bring-up and debug.

Parameters:
IN_W, 3, code width; output width OUT_W = 2**IN_W is a derived localparam, never overridden.
CNT_W, 16, width of the delivered-transaction counter.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst_n  input  1  synchronous, active-low reset.
in_valid  input  1  in_code is valid this cycle.
in_ready  output  1  block can accept a code this cycle.
in_code  input  IN_W  binary code to decode.
in_en  input  1  sampled with in_code; 0 means decode to all-zeros (no select).
out_valid  output  1  out_onehot is valid.
out_ready  input  1  downstream accepts out_onehot this cycle.
out_onehot  output  OUT_W  decoded one-hot (or zero) word.
xfer_cnt  output  CNT_W  count of completed output handshakes.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n; it acts on the rising edge of clk while rst_n = 0.
- Reset values: buffer empty; out_valid = 0; out_onehot = 0; xfer_cnt = 0. in_ready = 0 while rst_n = 0 and 1 on the first cycle after release.
- Input handshake: a code is accepted when in_valid && in_ready. Decoding happens at acceptance: bit in_code is set if in_en = 1, otherwise the word is all-zeros. The decoded word is written into the buffer.
- Latency: code accepted at edge N gives out_valid = 1 with its word from cycle N+1 if the buffer was empty. There is no combinational path from in_* to out_*.
- Output handshake: the head entry leaves when out_valid && out_ready. out_onehot is held stable while out_valid = 1 and out_ready = 0. out_onehot = 0 whenever out_valid = 0.
- State machine over buffer occupancy:
  - EMPTY: out_valid = 0, in_ready = 1. A push goes to ONE.
  - ONE: out_valid = 1, in_ready = 1. Push and pop in the same cycle stay in ONE, head replaced by the new entry. Push only goes to FULL. Pop only goes to EMPTY.
  - FULL: out_valid = 1, in_ready = 0. A pop goes to ONE. No push is possible.
- in_ready depends only on the state register, never combinationally on out_ready.
- Order: FIFO; codes are delivered in acceptance order, none dropped, none duplicated.
- xfer_cnt: +1 on each output handshake; wraps from 2**CNT_W-1 to 0 with no flag.
- Reset mid-operation: buffered entries are discarded; the state and all outputs return to their reset values on that edge.
- in_code values: every value 0..OUT_W-1 is legal, so there is no invalid-code case. in_en = 0 entries still occupy a slot and are counted.

Optional Feature:
Macro DEC_PARITY_EN.
- Defined:
  - Adds input in_parity (1 bit, even parity over in_code) and outputs err_pulse (1) and err_cnt (8).
  - An accepted code whose parity mismatches is consumed (in_ready behaves normally) but not enqueued.
  - err_pulse = 1 for the cycle after acceptance; err_cnt +1, saturating at 255.
  - err_pulse and err_cnt reset to 0.
- Undefined: none of these ports or this logic exist, and all codes are enqueued.

Decomposition:
- Shared package dec_pkg: IN_W default, OUT_W derivation function, occupancy state enum (EMPTY/ONE/FULL), and a parity helper function.
- One natural sub-module, dec_skid_buf: 2-entry valid/ready buffer parameterized on data width, reused later by other pipelined codec blocks.
- The decode itself stays inline.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, out_valid = 0, out_onehot = 0, xfer_cnt = 0.
- Sweep: out_ready = 1, push codes 0..7 back-to-back with in_en = 1 -> out_onehot sequence 00000001 .. 10000000, each one cycle after acceptance, xfer_cnt = 8.
- Back-pressure: out_ready = 0, push 3, 5, 6 -> only 3 and 5 are accepted, in_ready = 0 after the second, out_onehot stays 00001000. Then out_ready = 1 -> 00001000, then 00100000, then 6 is accepted and 01000000 is delivered.
- Disable: push code 4 with in_en = 0 -> out_onehot = 00000000 with out_valid = 1, xfer_cnt increments.
- Mid-operation reset: buffer FULL, then pulse rst_n = 0 for one cycle -> next cycle out_valid = 0, xfer_cnt = 0, no stale entry appears afterward.
- DEC_PARITY_EN: push code 3 with in_parity = 1 (wrong) -> no output, err_pulse = 1 for one cycle, err_cnt = 1. Push code 3 with in_parity = 0 -> out_onehot = 00001000.

Source files
------------

// File: rtl/dec_pkg.sv
// dec_pkg: shared definitions for the pipelined one-hot decoder family.
//   DEC_IN_W   default code width
//   occ_e      occupancy state of the 2-entry output buffer
//   dec_out_w  one-hot width derived from a code width
//   even_par   even-parity bit over a (zero-extended) code
package dec_pkg;

  localparam int unsigned DEC_IN_W = 3;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  function automatic int unsigned dec_out_w(input int unsigned in_w);
    return 32'd1 << in_w;
  endfunction

  // Parity bit that makes the total number of ones even.
  function automatic logic even_par(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/dec_skid_buf.sv
// dec_skid_buf: 2-entry valid/ready buffer, data width DW.
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   in_valid_i/in_ready_o   upstream handshake, in_data_i pushed on accept
//   out_valid_o/out_ready_i downstream handshake, out_data_o is the head
// in_ready_o is a function of the occupancy register only (plus reset), so
// downstream ready never propagates combinationally upstream. out_data_o is
// driven straight from the head register and is zero whenever empty.
module dec_skid_buf
  import dec_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o
);

  occ_e          state_q;
  logic [DW-1:0] head_q;
  logic [DW-1:0] tail_q;
  logic          push;
  logic          pop;

  assign in_ready_o  = rst_n_i && (state_q != OCC_FULL);
  assign out_valid_o = (state_q != OCC_EMPTY);
  assign out_data_o  = head_q;

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= OCC_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (push) begin
            head_q  <= in_data_i;
            state_q <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          case ({push, pop})
            2'b11: head_q <= in_data_i;     // head leaves, new word takes its place
            2'b10: begin
              tail_q  <= in_data_i;
              state_q <= OCC_FULL;
            end
            2'b01: begin
              head_q  <= '0;                // keep output zero while empty
              state_q <= OCC_EMPTY;
            end
            default: ;
          endcase
        end
        OCC_FULL: begin
          if (pop) begin
            head_q  <= tail_q;
            tail_q  <= '0;
            state_q <= OCC_ONE;
          end
        end
        default: state_q <= OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/decoder3to8_pipe.sv
// decoder3to8_pipe: registered IN_W-to-2**IN_W one-hot decoder with
// valid/ready on both sides and a 2-entry output buffer.
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       input handshake; in_code, in_en sampled on accept
//   out_valid/out_ready     output handshake; out_onehot is the decoded word
//   xfer_cnt                wrapping count of output handshakes
// Optional build macro DEC_PARITY_EN adds:
//   in_parity               even parity over in_code
//   err_pulse               one cycle after a parity-failing code is accepted
//   err_cnt                 saturating count of parity failures
// A parity-failing code is consumed but never enqueued.
module decoder3to8_pipe
  import dec_pkg::*;
#(
  parameter int unsigned IN_W  = DEC_IN_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_W-1:0]             in_code,
  input  logic                        in_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [dec_out_w(IN_W)-1:0]  out_onehot,
  output logic [CNT_W-1:0]            xfer_cnt
`ifdef DEC_PARITY_EN
  ,
  input  logic                        in_parity,
  output logic                        err_pulse,
  output logic [7:0]                  err_cnt
`endif
);

  localparam int unsigned OUT_W = dec_out_w(IN_W);

  // Decode at acceptance; the buffer register is the only pipeline stage.
  logic [OUT_W-1:0] dec_word;
  for (genvar b = 0; b < OUT_W; b++) begin : g_dec
    assign dec_word[b] = in_en && (in_code == IN_W'(b));
  end

  logic code_ok;
`ifdef DEC_PARITY_EN
  assign code_ok = (in_parity == even_par(32'(in_code)));
`else
  assign code_ok = 1'b1;
`endif

  // Bad codes are hidden from the buffer but still see a normal in_ready.
  logic buf_in_valid;
  assign buf_in_valid = in_valid && code_ok;

  dec_skid_buf #(.DW(OUT_W)) u_buf (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .in_valid_i (buf_in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (dec_word),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_onehot)
  );

  logic [CNT_W-1:0] xfer_cnt_q;
  logic [CNT_W-1:0] xfer_cnt_d;
  assign xfer_cnt_d = xfer_cnt_q + CNT_W'(out_valid && out_ready);
  assign xfer_cnt   = xfer_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) xfer_cnt_q <= '0;
    else        xfer_cnt_q <= xfer_cnt_d;
  end

`ifdef DEC_PARITY_EN
  logic       bad_acc;
  logic       err_pulse_q;
  logic [7:0] err_cnt_q;
  logic [7:0] err_cnt_d;

  assign bad_acc   = in_valid && in_ready && !code_ok;
  assign err_cnt_d = (bad_acc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_pulse_q <= bad_acc;
      err_cnt_q   <= err_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_decoder3to8_pipe.sv
// tb_decoder3to8_pipe: directed bench for decoder3to8_pipe with a queue-based
// reference model compared on every falling edge, plus literal checks sampled
// 1 time unit after rising edges. Build with DEC_PARITY_EN to cover parity.
module tb_decoder3to8_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_code;
  logic        in_en;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_onehot;
  logic [15:0] xfer_cnt;
  logic        in_parity;
`ifdef DEC_PARITY_EN
  logic        err_pulse;
  logic [7:0]  err_cnt;
`endif

  int ntest = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  decoder3to8_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_en     (in_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_onehot(out_onehot),
    .xfer_cnt  (xfer_cnt)
`ifdef DEC_PARITY_EN
    ,
    .in_parity (in_parity),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of capacity two holding decoded words.
  logic [7:0]  mq[$];
  logic [15:0] m_cnt = '0;
  logic        m_err_pulse = 1'b0;
  logic [7:0]  m_err_cnt = '0;
  bit          started = 0;

  always @(posedge clk) begin
    logic acc, pop, ok;
    logic [7:0] tmp;
    if (!rst_n) begin
      mq.delete();
      m_cnt = '0;
      m_err_pulse = 1'b0;
      m_err_cnt = '0;
      started = 1;
    end else begin
      acc = in_valid && (mq.size() < 2);
      pop = (mq.size() > 0) && out_ready;
      ok  = 1'b1;
`ifdef DEC_PARITY_EN
      ok  = (in_parity == ^in_code);
`endif
      if (pop) begin
        tmp = mq.pop_front();
        m_cnt = m_cnt + 16'd1;
      end
      if (acc && ok) mq.push_back(in_en ? 8'(1 << in_code) : 8'h00);
      m_err_pulse = acc && !ok;
      if (acc && !ok && m_err_cnt != 8'hFF) m_err_cnt = m_err_cnt + 8'd1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_in_ready", 64'(in_ready), 64'(rst_n && (mq.size() < 2)));
      chk("m_out_valid", 64'(out_valid), 64'(mq.size() > 0));
      chk("m_out_onehot", 64'(out_onehot), 64'((mq.size() > 0) ? mq[0] : 8'h00));
      chk("m_xfer_cnt", 64'(xfer_cnt), 64'(m_cnt));
`ifdef DEC_PARITY_EN
      chk("m_err_pulse", 64'(err_pulse), 64'(m_err_pulse));
      chk("m_err_cnt", 64'(err_cnt), 64'(m_err_cnt));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer a code until accepted (bounded), then drop in_valid.
  task automatic push(input logic [2:0] c, input logic en, input logic par);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; in_code = c; in_en = en; in_parity = par;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = in_ready;
      cyc();
    end
    in_valid = 1'b0;
    chk("push_accept", 64'(acc), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_code = 3'd0; in_en = 1'b1;
    in_parity = 1'b0; out_ready = 1'b0;

    // Reset held with in_valid asserted.
    repeat (3) begin
      cyc();
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_onehot", 64'(out_onehot), 64'd0);
      chk("rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    cyc();
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    // Sweep 0..7, one cycle latency each.
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      push(3'(c), 1'b1, ^(3'(c)));
      chk("sweep_valid", 64'(out_valid), 64'd1);
      chk("sweep_onehot", 64'(out_onehot), 64'(8'd1 << c));
    end
    cyc();
    chk("sweep_cnt", 64'(xfer_cnt), 64'd8);
    chk("sweep_drained", 64'(out_valid), 64'd0);

    // Back-pressure: 3 and 5 fill the buffer, 6 waits.
    out_ready = 1'b0;
    push(3'd3, 1'b1, 1'b0);
    chk("bp_head3", 64'(out_onehot), 64'h08);
    push(3'd5, 1'b1, 1'b0);
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    chk("bp_full_head", 64'(out_onehot), 64'h08);
    in_valid = 1'b1; in_code = 3'd6; in_en = 1'b1; in_parity = 1'b0;
    repeat (2) begin
      cyc();
      chk("bp_hold_onehot", 64'(out_onehot), 64'h08);
      chk("bp_hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    cyc();
    chk("bp_pop3_head5", 64'(out_onehot), 64'h20);
    chk("bp_ready_again", 64'(in_ready), 64'd1);
    cyc();
    chk("bp_head6", 64'(out_onehot), 64'h40);
    in_valid = 1'b0;
    cyc();
    chk("bp_cnt", 64'(xfer_cnt), 64'd11);

    // Disabled decode still occupies a slot and is counted.
    push(3'd4, 1'b0, 1'b1);
    chk("dis_valid", 64'(out_valid), 64'd1);
    chk("dis_onehot", 64'(out_onehot), 64'h00);
    cyc();
    chk("dis_cnt", 64'(xfer_cnt), 64'd12);

    // Reset while full.
    out_ready = 1'b0;
    push(3'd1, 1'b1, 1'b1);
    push(3'd2, 1'b1, 1'b1);
    chk("mr_full", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    cyc();
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_cnt", 64'(xfer_cnt), 64'd0);
    chk("mr_onehot", 64'(out_onehot), 64'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (3) begin
      cyc();
      chk("mr_no_stale", 64'(out_valid), 64'd0);
    end

`ifdef DEC_PARITY_EN
    push(3'd3, 1'b1, 1'b1);
    chk("par_err_pulse", 64'(err_pulse), 64'd1);
    chk("par_no_out", 64'(out_valid), 64'd0);
    chk("par_err_cnt", 64'(err_cnt), 64'd1);
    cyc();
    chk("par_pulse_clear", 64'(err_pulse), 64'd0);
`endif
    push(3'd3, 1'b1, 1'b0);
    chk("par_good", 64'(out_onehot), 64'h08);
    cyc();

    // Mixed traffic checked by the model.
    for (int i = 0; i < 150; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_code   = 3'($urandom_range(0, 7));
      in_en     = ($urandom_range(0, 3) != 0);
      in_parity = (^in_code) ^ ($urandom_range(0, 7) == 0);
      out_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();
    chk("final_empty", 64'(out_valid), 64'd0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
